// File: rtl/sdram_rd_arbiter.sv
// Round-robin burst arbiter sharing one SDRAM read port between the weight loader (0)
// and the input-feature loader (1), with an in-order tag FIFO steering returned beats.
module sdram_rd_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 200,
  parameter int TAG_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              R0_RE_N,
  input  logic [ADDR_W-1:0] R0_ADDR,
  output logic              R0_WAIT,
  output logic              R0_RDVALID,
  input  logic              R1_RE_N,
  input  logic [ADDR_W-1:0] R1_ADDR,
  output logic              R1_WAIT,
  output logic              R1_RDVALID,
  output logic              SDRAM_RE_N,
  output logic [ADDR_W-1:0] SDRAM_ADDR,
  input  logic              SDRAM_WAIT,
  input  logic              SDRAM_RDVALID,
  input  logic [DATA_W-1:0] SDRAM_RDDATA,
  output logic [DATA_W-1:0] RDDATA,
  output logic              ERR_UNDERFLOW
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [PTR_W:0]   FIFO_CAP = (PTR_W + 1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           state, state_next;
  logic             last_grant, last_grant_next;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_next;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       fifo_cnt;
  logic                 fifo_full, fifo_empty;
  logic                 accept, push_tag, pop, head_tag;

  assign fifo_full  = (fifo_cnt == FIFO_CAP);
  assign fifo_empty = (fifo_cnt == '0);
  assign head_tag   = tag_mem[rd_ptr];
  assign pop        = SDRAM_RDVALID && !fifo_empty;
  assign R0_RDVALID = pop && !head_tag;
  assign R1_RDVALID = pop && head_tag;
  assign RDDATA     = SDRAM_RDDATA;

  // Preemption looks at the count including this cycle's beat, so the holder
  // is cut off right after its MAX_BURST-th beat rather than one beat later.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    beat_cnt_next   = beat_cnt;
    SDRAM_RE_N      = 1'b1;
    SDRAM_ADDR      = R0_ADDR;
    R0_WAIT         = 1'b1;
    R1_WAIT         = 1'b1;
    accept          = 1'b0;
    push_tag        = 1'b0;
    case (state)
      IDLE: begin
        if (!R0_RE_N && (R1_RE_N || last_grant)) begin
          state_next      = GNT0;
          last_grant_next = 1'b0;
          beat_cnt_next   = '0;
        end else if (!R1_RE_N) begin
          state_next      = GNT1;
          last_grant_next = 1'b1;
          beat_cnt_next   = '0;
        end
      end
      GNT0: begin
        SDRAM_ADDR = R0_ADDR;
        SDRAM_RE_N = R0_RE_N | fifo_full;
        R0_WAIT    = SDRAM_WAIT | fifo_full;
        accept     = !R0_RE_N && !SDRAM_WAIT && !fifo_full;
        if (accept && (beat_cnt != CNT_MAX))
          beat_cnt_next = beat_cnt + 1'b1;
        if (R0_RE_N || (!R1_RE_N && (beat_cnt_next == CNT_MAX)))
          state_next = IDLE;
      end
      GNT1: begin
        SDRAM_ADDR = R1_ADDR;
        SDRAM_RE_N = R1_RE_N | fifo_full;
        R1_WAIT    = SDRAM_WAIT | fifo_full;
        accept     = !R1_RE_N && !SDRAM_WAIT && !fifo_full;
        push_tag   = 1'b1;
        if (accept && (beat_cnt != CNT_MAX))
          beat_cnt_next = beat_cnt + 1'b1;
        if (R1_RE_N || (!R0_RE_N && (beat_cnt_next == CNT_MAX)))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      beat_cnt   <= beat_cnt_next;
    end
  end

  // Tag storage needs no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (accept)
      tag_mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ERR_UNDERFLOW <= 1'b0;
    else if (SDRAM_RDVALID && fifo_empty)
      ERR_UNDERFLOW <= 1'b1;
  end

endmodule

// File: doc/sdram_rd_arbiter.md
Name: sdram_rd_arbiter

Overview:
- Shares the single SDRAM read port between two read requesters: requester 0 is the weight loader and requester 1 is the input-feature loader.
- Grants whole bursts, rotates priority round-robin, and force-preempts a burst after MAX_BURST accepted beats if the other requester is waiting.
- Tracks every accepted read in an in-order tag FIFO so each returned data beat is steered to the requester that issued it.
- Sits between the loaders and the SDRAM controller's Avalon-style read interface.

Parameters:
ADDR_W, 25, SDRAM address width; equals `RAM_ADR_W.
DATA_W, 256, SDRAM read data width.
MAX_BURST, 200, accepted beats after which the grant is dropped if the other requester is pending; must be ≥1.
TAG_DEPTH, 32, depth of the outstanding-read tag FIFO; must be a power of 2, ≥2.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
R0_RE_N  in  1  requester 0 read request, active low.
R0_ADDR  in  ADDR_W  requester 0 address.
R0_WAIT  out  1  requester 0 stall; a beat is accepted only when this is 0.
R0_RDVALID  out  1  returned beat belongs to requester 0.
R1_RE_N, R1_ADDR, R1_WAIT, R1_RDVALID  same as requester 0, for requester 1.
SDRAM_RE_N  out  1  read strobe to the controller, active low.
SDRAM_ADDR  out  ADDR_W  address to the controller.
SDRAM_WAIT  in  1  controller waitrequest.
SDRAM_RDVALID  in  1  controller read-data valid.
SDRAM_RDDATA  in  DATA_W  controller read data.
RDDATA  out  DATA_W  SDRAM_RDDATA passed through combinationally to both requesters.
ERR_UNDERFLOW  out  1  sticky: SDRAM_RDVALID arrived while the tag FIFO was empty.

Behaviour:
- State register values: IDLE, GNT0, GNT1.
- Register reset values: state=IDLE, last_grant=1 (so requester 0 wins the first arbitration), beat_cnt=0, FIFO empty, ERR_UNDERFLOW=0.
- Reset asserted mid-burst returns to IDLE immediately and discards all outstanding tags.
- Outputs are combinational from the registered state:
  - IDLE: SDRAM_RE_N=1, SDRAM_ADDR=R0_ADDR, R0_WAIT=1, R1_WAIT=1.
  - GNTx: SDRAM_ADDR=Rx_ADDR; SDRAM_RE_N=Rx_RE_N | fifo_full; Rx_WAIT=SDRAM_WAIT | fifo_full; the non-granted requester's WAIT=1.
- Accepted beat: state GNTx, Rx_RE_N=0, SDRAM_WAIT=0, FIFO not full. On each accepted beat:
  - push tag x into the FIFO;
  - increment beat_cnt (saturating at MAX_BURST).
- IDLE transitions:
  - only R0 requesting (RE_N=0) → GNT0.
  - only R1 requesting → GNT1.
  - both requesting → grant the one that is not last_grant.
  - neither → stay in IDLE.
  - On any grant: beat_cnt←0 and last_grant←winner.
  - The arbitration cycle accepts no beat, so grant-to-first-accept latency is ≥1 cycle.
- GNTx transitions back to IDLE:
  - Rx_RE_N=1 (burst released), or
  - beat_cnt=MAX_BURST and the other requester's RE_N=0 (preemption). The preempted requester keeps RE_N low, sees WAIT=1 in IDLE, and stalls without losing its beat.
- Otherwise GNTx holds. The FIFO-full stall never changes state.
- FIFO full with a pop in the same cycle: the push is still blocked (full is sampled from registered occupancy).
- Read return:
  - On SDRAM_RDVALID=1 with FIFO non-empty: pop the head; R0_RDVALID=(head==0), R1_RDVALID=(head==1), same cycle, combinational.
  - Simultaneous push and pop: occupancy unchanged; the pointers wrap modulo TAG_DEPTH.
  - SDRAM_RDVALID=1 with FIFO empty: both RDVALIDs stay 0, ERR_UNDERFLOW sets and holds until reset.
- Returns are strictly in order; the controller is required to return data in request order.

Test Plan:
- R0 only, 16 addresses from 0x100, SDRAM_WAIT=0 → IDLE 1 cycle, then 16 consecutive SDRAM_RE_N=0 beats with addresses 0x100..0x10F; R1_WAIT=1 throughout; state returns to IDLE when R0_RE_N rises.
- R0 and R1 both request from reset → GNT0 first; after the R0 burst, R1 is granted; on the next simultaneous request R0 wins again (round-robin alternation).
- MAX_BURST=4, R0 holds a 10-beat request while R1 requests → R0 gets 4 beats, IDLE, R1 burst, IDLE, then R0 resumes at beat 5 with the address unchanged and no beat dropped.
- TAG_DEPTH=4, no SDRAM_RDVALID → exactly 4 accepted beats, then SDRAM_RE_N=1 and R0_WAIT=1; one RDVALID pulse → R0_RDVALID=1 and exactly one more beat is accepted the following cycle.
- Interleaved tags [0,0,1,0,1] with 3-cycle return latency → RDVALID routing R0,R0,R1,R0,R1; RDDATA passed through unchanged.
- SDRAM_RDVALID with FIFO empty → ERR_UNDERFLOW=1 and no RDVALID pulse; rst asserted mid-burst → SDRAM_RE_N=1 the same cycle and ERR_UNDERFLOW=0.
